// File: rtl/incr16_rr_sched.sv
// incr16_rr_sched: round-robin sharing of one 16-bit incrementer among NREQ requesters (define INCR16_SCHED_OVF_CNT_EN for the saturating wrap counter ovf_cnt)
module incr16_rr_sched #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
`ifdef INCR16_SCHED_OVF_CNT_EN
  output logic [15:0]          ovf_cnt,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_data,
  output logic                 res_cy,
  output logic [IDW-1:0]       res_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, win;
  logic any, can_issue, issue, cy;
  logic [15:0] operand, sum;
  int idx;
  assign res_valid = state == FULL;
  assign can_issue = (state == EMPTY) | res_ready;
  assign issue = any & can_issue & rst_n;
  assign req_ready = issue ? NREQ'(1) << win : '0;
  assign operand = req_data[16*win +: 16];
  assign {cy, sum} = {1'b0, operand} + 17'd1;
  // scan from rr_ptr upward with wrap; descending loop lets the nearest valid requester win
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        win = IDW'(idx);
        any = 1'b1;
      end
    end
  end
  // output register doubles as the EMPTY/FULL arbiter state; a drain and an issue may share one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      res_data <= '0;
      res_cy <= 1'b0;
      res_id <= '0;
      rr_ptr <= '0;
    end else if (issue) begin
      state <= FULL;
      res_data <= sum;
      res_cy <= cy;
      res_id <= win;
      rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (res_ready) begin
      state <= EMPTY;
    end
  end
`ifdef INCR16_SCHED_OVF_CNT_EN
  // count issued wraps, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt <= '0;
    else if (issue & cy & ~&ovf_cnt) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_incr16_rr_sched.sv
// tb_incr16_rr_sched: scoreboard bench for the round-robin incrementer scheduler
module tb_incr16_rr_sched;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst_n = 1'b0, res_ready = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*16-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic res_valid, res_cy;
  logic [15:0] res_data;
  logic [1:0] res_id;
`ifdef INCR16_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif
  always #5 clk = ~clk;
  incr16_rr_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
`ifdef INCR16_SCHED_OVF_CNT_EN
    .ovf_cnt(ovf_cnt),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cy(res_cy), .res_id(res_id)
  );
  typedef struct packed {logic [1:0] id; logic [15:0] d; logic cy;} res_t;
  res_t q[$];
  int checks = 0, failures = 0;
  int m_ptr = 0, m_win = -1;
  bit m_issue = 1'b0;
  int hold[NREQ];

  // one clock: check outputs vs scoreboard, model arbitration, advance to just past the edge
  task automatic cycle();
    int w;
    logic [NREQ-1:0] er;
    logic [15:0] op;
    #3;
    checks++;
    if (res_valid !== (q.size() != 0)) begin
      failures++;
      $display("FAIL sb_valid got=%b exp=%b", res_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if ({res_id, res_data, res_cy} !== q[0]) begin
        failures++;
        $display("FAIL sb_result got id=%0d data=%h cy=%b exp id=%0d data=%h cy=%b",
                 res_id, res_data, res_cy, q[0].id, q[0].d, q[0].cy);
      end
    end
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    m_issue = w >= 0 && (q.size() == 0 || res_ready);
    er = m_issue ? NREQ'(1) << w : '0;
    checks++;
    if (req_ready !== er) begin
      failures++;
      $display("FAIL req_ready got=%b exp=%b", req_ready, er);
    end
    if (q.size() != 0 && res_ready) q.delete(0);
    if (m_issue) begin
      op = req_data[16*w +: 16];
      for (int i = 0; i < NREQ; i++)
        if (i != w && req_valid[i]) begin
          hold[i]++;
          checks++;
          if (hold[i] >= NREQ) begin
            failures++;
            $display("FAIL fairness req=%0d waited=%0d issues limit=%0d", i, hold[i], NREQ - 1);
          end
        end
      hold[w] = 0;
      q.push_back({2'(w), op + 16'd1, op == 16'hFFFF});
      m_ptr = (w + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) if (!req_valid[i]) hold[i] = 0;
    m_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    #2;
    q.delete();
    m_ptr = 0;
    m_win = -1;
    m_issue = 1'b0;
    for (int i = 0; i < NREQ; i++) hold[i] = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #1;
    checks++;
    if ({res_valid, res_data, res_cy, res_id, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h cy=%b id=%0d ready=%b exp all zero",
               res_valid, res_data, res_cy, res_id, req_ready);
    end
`ifdef INCR16_SCHED_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'h0) begin failures++; $display("FAIL reset_ovf got=%h exp=0000", ovf_cnt); end
`endif
    req_valid = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 16'h0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_mid got valid=%b data=%h ready=%b exp 0 0000 0000", res_valid, res_data, req_ready);
    end
    q.delete();
    m_ptr = 0;
    #1 rst_n = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    cycle();
    checks++;
    if (res_id !== 2'd0) begin failures++; $display("FAIL reset_ptr got id=%0d exp=0", res_id); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data = '0;
    req_data[47:32] = 16'h00FF;
    res_ready = 1'b1;
    cycle();
    req_valid = '0;
    checks++;
    if ({res_valid, res_data, res_cy, res_id} !== {1'b1, 16'h0100, 1'b0, 2'd2}) begin
      failures++;
      $display("FAIL single got valid=%b data=%h cy=%b id=%0d exp 1 0100 0 2", res_valid, res_data, res_cy, res_id);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_data = {$urandom, $urandom};
      cycle();
      checks++;
      if (res_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_order step=%0d got=%0d exp=%0d", k, res_id, k % 4); end
    end
    req_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_backpressure();
    res_t held;
    do_reset();
    req_valid = 4'b0011;
    req_data = {$urandom, $urandom};
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    held = {res_id, res_data, res_cy};
    for (int k = 0; k < 3; k++) begin
      req_data = {$urandom, $urandom};
      cycle();
      checks++;
      if (req_ready !== '0 || {res_id, res_data, res_cy} !== held) begin
        failures++;
        $display("FAIL stall step=%0d got ready=%b res=%h exp ready=0 res=%h", k, req_ready, {res_id, res_data, res_cy}, held);
      end
    end
    res_ready = 1'b1;
    cycle();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      failures++;
      $display("FAIL drain_issue got valid=%b id=%0d exp 1 1", res_valid, res_id);
    end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001;
    req_data = '0;
    req_data[15:0] = 16'hFFFF;
    res_ready = 1'b1;
    cycle();
    checks++;
    if (res_data !== 16'h0000 || res_cy !== 1'b1) begin
      failures++;
      $display("FAIL wrap got data=%h cy=%b exp 0000 1", res_data, res_cy);
    end
`ifdef INCR16_SCHED_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd1) begin failures++; $display("FAIL ovf_first got=%h exp=0001", ovf_cnt); end
`endif
    req_data[15:0] = 16'hFFFE;
    cycle();
    checks++;
    if (res_data !== 16'hFFFF || res_cy !== 1'b0) begin
      failures++;
      $display("FAIL no_wrap got data=%h cy=%b exp FFFF 0", res_data, res_cy);
    end
`ifdef INCR16_SCHED_OVF_CNT_EN
    req_data[15:0] = 16'hFFFF;
    repeat (65534) cycle();
    checks++;
    if (ovf_cnt !== 16'hFFFF) begin failures++; $display("FAIL ovf_full got=%h exp=FFFF", ovf_cnt); end
    cycle();
    checks++;
    if (ovf_cnt !== 16'hFFFF) begin failures++; $display("FAIL ovf_sat got=%h exp=FFFF", ovf_cnt); end
`endif
    req_valid = '0;
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      res_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && !(m_issue && m_win == i)) req_valid[i] = $urandom_range(0, 7) != 0;
        else req_valid[i] = $urandom_range(0, 1) != 0;
      req_data = {$urandom, $urandom};
      cycle();
    end
    req_valid = '0;
    res_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (q.size() != 0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got pending=%0d valid=%b exp 0 0", q.size(), res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
